subcarrier_nco: RTL and testbench
=================================

Name: subcarrier_nco

Overview:
Phase generator that sits directly upstream of the CORDIC sin/cos rotator. It produces the 20-bit phase word (full circle = 2^20) that drives the rotator's target_angle input, used for chroma subcarrier demodulation. The block is a 32-bit phase accumulator with double-buffered tuning and offset registers, applied only at line boundaries. It also provides a per-line phase capture and a valid strobe delayed to line up with the rotator's sin/cos outputs.

Parameters:
ACC_WIDTH, 32, accumulator width; the output phase is the top 20 bits; must be >= 20.
FTW_DEFAULT, 32'h40000000, reset value of the tuning word (fs = 4*fsc, i.e. +90 degrees per sample).
CORDIC_LATENCY, 10, delay in cycles from target_angle to rotator sin/cos; equals rotator STAGES.
RESYNC_ON_LINE, 1, 1 = line_start zeroes the accumulator in RUN; 0 = free-running across lines.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  level; low forces IDLE.
line_start  in  1  single-cycle pulse at the start of a line (burst reference point).
ftw_in  in  ACC_WIDTH  tuning word value.
ftw_load  in  1  pulse; writes ftw_in to the shadow tuning register.
offset_in  in  20  phase offset, unsigned modulo 2^20 (hue adjust / burst correction).
offset_load  in  1  pulse; writes offset_in to the shadow offset register.
target_angle  out  20  registered phase word that feeds the rotator.
angle_valid  out  1  target_angle is valid this cycle.
sincos_valid  out  1  angle_valid delayed by CORDIC_LATENCY cycles; qualifies rotator outputs.
line_phase  out  20  acc[top 20] captured at the most recent line_start in RUN.
update_pending  out  1  shadow ftw or offset written but not yet applied.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE, acc = 0, ftw_shadow = ftw_active = FTW_DEFAULT, offset_shadow = offset_active = 0.
  - All outputs 0, and the sincos_valid delay line is cleared.
- States IDLE, ARMED, RUN; the state is registered.
  - IDLE -> ARMED when enable = 1.
  - Any state -> IDLE on the next cycle when enable = 0. On IDLE entry, acc = 0, target_angle = 0 and angle_valid = 0. Shadow registers are kept.
  - ARMED -> RUN on line_start. In that cycle: acc <= ftw_active_new, ftw_active <= shadow, offset_active <= shadow, update_pending <= 0.
  - ARMED without line_start: acc stays at 0 and angle_valid = 0.
- RUN, each cycle:
  - acc <= acc + ftw_active, modulo 2^ACC_WIDTH (wraps silently).
  - target_angle <= acc[ACC_WIDTH-1 -: 20] + offset_active, modulo 2^20.
  - angle_valid <= 1.
  - target_angle lags acc by one cycle. The first valid angle after ARMED -> RUN equals offset_active, because acc was 0 in that cycle.
- line_start in RUN:
  - line_phase <= acc top 20 bits (pre-update value).
  - Shadow values are applied to the active registers and update_pending is cleared.
  - If RESYNC_ON_LINE = 1, acc <= new ftw_active, so the next target_angle = new offset. Otherwise acc <= acc + new ftw_active.
- Shadow writes:
  - ftw_load / offset_load write the shadow register and set update_pending.
  - If a load and line_start occur in the same cycle, the incoming value bypasses the shadow and is applied at that line_start; update_pending stays 0.
  - If both loads occur in one cycle, both registers are written.
  - A second load before line_start overwrites the first; only the last value is applied.
- The loads are accepted in every state except during rst.
- sincos_valid: a shift register of depth CORDIC_LATENCY fed by angle_valid.
  - It is not flushed on IDLE entry; it drains naturally.
  - The rotator's sin/cos for target_angle(t) is valid when sincos_valid(t+CORDIC_LATENCY) = 1.
- A line_start pulse in IDLE is ignored.
- Reset mid-RUN returns to the reset values on the next edge.

Test Plan:
1. rst, enable=1, line_start at cycle 5, FTW_DEFAULT -> target_angle 0x00000, 0x40000, 0x80000, 0xC0000, 0x00000 ... starting at cycle 6; angle_valid high from cycle 6; sincos_valid high from cycle 16.
2. Wrap: ftw_load 0xFFFFF000 then line_start -> target_angle steps by -1 (0x00000, 0xFFFFF, 0xFFFFE); with offset 0x00010 the sequence is 0x00010, 0x0000F, 0x0000E.
3. Deferred update: in RUN, ftw_load 0x20000000 at cycle 20 -> update_pending=1 and the step stays 0x40000 until line_start at cycle 30. Then, with RESYNC_ON_LINE=1, the step becomes 0x20000 from offset; update_pending=0.
4. Simultaneous: offset_load 0x12345 in the same cycle as line_start -> next target_angle = 0x12345; update_pending stays 0.
5. line_phase capture: RESYNC_ON_LINE=0, ftw 0x00100000, line_start every 100 cycles -> line_phase = 0x00000, 0x06400 (100*0x100), 0x0C800.
6. Disable and reset: enable low mid-RUN -> next cycle angle_valid=0 and target_angle=0; sincos_valid drops CORDIC_LATENCY cycles later. rst mid-RUN -> all outputs 0 on the next cycle; a line_start in IDLE produces no output.

Source files
------------

// File: rtl/subcarrier_nco.sv
// Subcarrier phase NCO: 32-bit phase accumulator feeding the CORDIC rotator's
// target_angle, with line-synchronous double-buffered tuning/offset registers,
// per-line phase capture and a valid strobe aligned to the rotator outputs.
module subcarrier_nco #(
  parameter int unsigned           ACC_WIDTH      = 32,
  parameter logic [ACC_WIDTH-1:0]  FTW_DEFAULT    = ACC_WIDTH'(32'h40000000),
  parameter int unsigned           CORDIC_LATENCY = 10,
  parameter bit                    RESYNC_ON_LINE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 line_start,
  input  logic [ACC_WIDTH-1:0] ftw_in,
  input  logic                 ftw_load,
  input  logic [19:0]          offset_in,
  input  logic                 offset_load,
  output logic [19:0]          target_angle,
  output logic                 angle_valid,
  output logic                 sincos_valid,
  output logic [19:0]          line_phase,
  output logic                 update_pending
);

  localparam int unsigned PW = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [ACC_WIDTH-1:0]     ftw_shadow_q, ftw_shadow_d;
  logic [ACC_WIDTH-1:0]     ftw_active_q, ftw_active_d;
  logic [PW-1:0]            offset_shadow_q, offset_shadow_d;
  logic [PW-1:0]            offset_active_q, offset_active_d;
  logic [PW-1:0]            target_angle_q, target_angle_d;
  logic                     angle_valid_q, angle_valid_d;
  logic [PW-1:0]            line_phase_q, line_phase_d;
  logic                     update_pending_q, update_pending_d;
  logic [CORDIC_LATENCY-1:0] sincos_pipe_q, sincos_pipe_d;

  logic [ACC_WIDTH-1:0]     ftw_new;
  logic [PW-1:0]            offset_new;
  logic [ACC_WIDTH-1:0]     acc_base;
  logic                     apply_line;

  // Next-state: FSM, accumulator, shadow/active registers and output words
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    ftw_active_d     = ftw_active_q;
    offset_active_d  = offset_active_q;
    target_angle_d   = target_angle_q;
    angle_valid_d    = angle_valid_q;
    line_phase_d     = line_phase_q;
    update_pending_d = update_pending_q;
    apply_line       = 1'b0;
    acc_base         = acc_q;

    // A load in the same cycle as an applied line_start bypasses the shadow.
    ftw_new         = ftw_load    ? ftw_in    : ftw_shadow_q;
    offset_new      = offset_load ? offset_in : offset_shadow_q;
    ftw_shadow_d    = ftw_new;
    offset_shadow_d = offset_new;
    if (ftw_load || offset_load) begin
      update_pending_d = 1'b1;
    end

    if (!enable) begin
      state_d        = IDLE;
      acc_d          = '0;
      target_angle_d = '0;
      angle_valid_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d        = ARMED;
          acc_d          = '0;
          target_angle_d = '0;
          angle_valid_d  = 1'b0;
        end
        ARMED: begin
          acc_d          = '0;
          target_angle_d = '0;
          angle_valid_d  = 1'b0;
          if (line_start) begin
            state_d    = RUN;
            apply_line = 1'b1;
            acc_base   = '0;
          end
        end
        RUN: begin
          angle_valid_d = 1'b1;
          if (line_start) begin
            apply_line   = 1'b1;
            line_phase_d = acc_q[ACC_WIDTH-1 -: PW];
            if (RESYNC_ON_LINE) begin
              acc_base = '0;
            end
          end else begin
            acc_d          = acc_q + ftw_active_q;
            target_angle_d = acc_q[ACC_WIDTH-1 -: PW] + offset_active_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Line boundary: new tuning takes effect from the (possibly zeroed) base phase.
    if (apply_line) begin
      ftw_active_d     = ftw_new;
      offset_active_d  = offset_new;
      update_pending_d = 1'b0;
      acc_d            = acc_base + ftw_new;
      target_angle_d   = acc_base[ACC_WIDTH-1 -: PW] + offset_new;
      angle_valid_d    = 1'b1;
    end
  end

  // Valid delay line matching the rotator pipeline depth
  always_comb begin
    sincos_pipe_d    = sincos_pipe_q;
    sincos_pipe_d[0] = angle_valid_q;
    for (int unsigned i = 1; i < CORDIC_LATENCY; i++) begin
      sincos_pipe_d[i] = sincos_pipe_q[i-1];
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      acc_q            <= '0;
      ftw_shadow_q     <= FTW_DEFAULT;
      ftw_active_q     <= FTW_DEFAULT;
      offset_shadow_q  <= '0;
      offset_active_q  <= '0;
      target_angle_q   <= '0;
      angle_valid_q    <= 1'b0;
      line_phase_q     <= '0;
      update_pending_q <= 1'b0;
      sincos_pipe_q    <= '0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      ftw_shadow_q     <= ftw_shadow_d;
      ftw_active_q     <= ftw_active_d;
      offset_shadow_q  <= offset_shadow_d;
      offset_active_q  <= offset_active_d;
      target_angle_q   <= target_angle_d;
      angle_valid_q    <= angle_valid_d;
      line_phase_q     <= line_phase_d;
      update_pending_q <= update_pending_d;
      sincos_pipe_q    <= sincos_pipe_d;
    end
  end

  assign target_angle   = target_angle_q;
  assign angle_valid    = angle_valid_q;
  assign sincos_valid   = sincos_pipe_q[CORDIC_LATENCY-1];
  assign line_phase     = line_phase_q;
  assign update_pending = update_pending_q;

endmodule

// File: tb/tb_subcarrier_nco.sv
// Testbench for subcarrier_nco: directed scenarios plus randomized traffic,
// checked against a sample-index/phase-sum reference model. Two instances share
// the stimulus: line-resync (default) and free-running across lines.
module tb_subcarrier_nco;

  localparam int unsigned LAT = 10;
  localparam logic [31:0] DEF = 32'h40000000;

  logic        clk = 1'b0;
  logic        rst, enable, line_start, ftw_load, offset_load;
  logic [31:0] ftw_in;
  logic [19:0] offset_in;

  logic [19:0] tgt_r, lp_r, tgt_f, lp_f;
  logic        av_r, sv_r, up_r, av_f, sv_f, up_f;

  int errors = 0;
  int checks = 0;

  subcarrier_nco dut_r (
    .clk(clk), .rst(rst), .enable(enable), .line_start(line_start),
    .ftw_in(ftw_in), .ftw_load(ftw_load), .offset_in(offset_in), .offset_load(offset_load),
    .target_angle(tgt_r), .angle_valid(av_r), .sincos_valid(sv_r),
    .line_phase(lp_r), .update_pending(up_r)
  );

  subcarrier_nco #(.RESYNC_ON_LINE(1'b0)) dut_f (
    .clk(clk), .rst(rst), .enable(enable), .line_start(line_start),
    .ftw_in(ftw_in), .ftw_load(ftw_load), .offset_in(offset_in), .offset_load(offset_load),
    .target_angle(tgt_f), .angle_valid(av_f), .sincos_valid(sv_f),
    .line_phase(lp_f), .update_pending(up_f)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 waiting for first line, 2 running
  int              m_st;
  logic [31:0]     m_ftw, m_ftw_sh;
  logic [19:0]     m_off, m_off_sh;
  longint unsigned m_k;      // samples since last line (resync instance)
  logic [63:0]     m_phf;    // running phase sum (free-running instance)
  logic [19:0]     e_tgt_r, e_tgt_f, e_lp_r, e_lp_f;
  logic            e_av, e_sv, e_up;
  bit              vq[$];    // angle_valid history, oldest first

  function automatic logic [19:0] top20(input logic [63:0] x);
    return x[31:12];
  endfunction

  task automatic model_quiet();
    e_tgt_r = '0;
    e_tgt_f = '0;
    e_av    = 1'b0;
    m_phf   = '0;
  endtask

  task automatic model_step();
    logic [31:0] nf;
    logic [19:0] no;
    nf = ftw_load    ? ftw_in    : m_ftw_sh;
    no = offset_load ? offset_in : m_off_sh;
    if (rst) begin
      m_st = 0; m_ftw = DEF; m_ftw_sh = DEF; m_off = '0; m_off_sh = '0;
      m_k = 0; m_phf = '0;
      e_tgt_r = '0; e_tgt_f = '0; e_lp_r = '0; e_lp_f = '0; e_av = 1'b0; e_up = 1'b0;
      vq.delete();
      for (int i = 0; i < int'(LAT); i++) vq.push_back(1'b0);
    end else begin
      m_ftw_sh = nf;
      m_off_sh = no;
      if (ftw_load || offset_load) e_up = 1'b1;
      if (!enable) begin
        m_st = 0; model_quiet();
      end else if (m_st == 0) begin
        m_st = 1; model_quiet();
      end else if (m_st == 1 && !line_start) begin
        model_quiet();
      end else if (line_start) begin
        if (m_st == 2) begin
          e_lp_r = top20(64'(m_k) * 64'(m_ftw));
          e_lp_f = top20(m_phf);
        end else begin
          m_phf = '0;
        end
        m_st = 2; m_ftw = nf; m_off = no; e_up = 1'b0; e_av = 1'b1;
        e_tgt_r = no;
        m_k = 1;
        e_tgt_f = top20(m_phf) + no;
        m_phf = m_phf + 64'(nf);
      end else begin
        e_av = 1'b1;
        e_tgt_r = top20(64'(m_k) * 64'(m_ftw)) + m_off;
        m_k++;
        e_tgt_f = top20(m_phf) + m_off;
        m_phf = m_phf + 64'(m_ftw);
      end
    end
    vq.push_back(e_av);
    if (vq.size() > int'(LAT) + 1) void'(vq.pop_front());
    e_sv = vq[0];
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    line_start = 1'b0; ftw_load = 1'b0; offset_load = 1'b0;
    ftw_in = '0; offset_in = '0;
  endtask

  // Reset, enable, and issue the first line_start so the NCO is in RUN.
  task automatic start_run();
    idle_inputs();
    rst = 1'b1; enable = 1'b0; tick();
    rst = 1'b0; enable = 1'b1; tick(); tick();
    line_start = 1'b1; tick(); line_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; enable = 1'b1; tick(); tick();
    checks++;
    if ({tgt_r, lp_r, av_r, sv_r, up_r} !== 43'd0) begin
      errors++; $display("FAIL reset_r: got tgt=%h lp=%h av=%b sv=%b up=%b want all 0", tgt_r, lp_r, av_r, sv_r, up_r);
    end
    checks++;
    if ({tgt_f, lp_f, av_f, sv_f, up_f} !== 43'd0) begin
      errors++; $display("FAIL reset_f: got tgt=%h lp=%h av=%b sv=%b up=%b want all 0", tgt_f, lp_f, av_f, sv_f, up_f);
    end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    logic [19:0] exp_t;
    logic        exp_v;
    start_run();
    checks++;
    if (tgt_r !== 20'h00000 || av_r !== 1'b1) begin
      errors++; $display("FAIL startup_first: got tgt=%h av=%b want 00000/1", tgt_r, av_r);
    end
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_t = 20'(n * 32'h40000);
      exp_v = (n >= int'(LAT));
      checks++;
      if (tgt_r !== exp_t || sv_r !== exp_v || av_r !== 1'b1) begin
        errors++; $display("FAIL startup_seq n=%0d: got tgt=%h sv=%b av=%b want %h/%b/1", n, tgt_r, sv_r, av_r, exp_t, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    logic [19:0] want[3];
    want[0] = 20'h00010; want[1] = 20'h0000F; want[2] = 20'h0000E;
    start_run();
    tick();
    ftw_load = 1'b1; ftw_in = 32'hFFFFF000; offset_load = 1'b1; offset_in = 20'h00010;
    tick();
    ftw_load = 1'b0; offset_load = 1'b0;
    checks++;
    if (up_r !== 1'b1) begin
      errors++; $display("FAIL wrap_pending: got %b want 1", up_r);
    end
    line_start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick(); line_start = 1'b0;
      checks++;
      if (tgt_r !== want[n]) begin
        errors++; $display("FAIL wrap_seq n=%0d: got %h want %h", n, tgt_r, want[n]);
      end
    end
  endtask

  task automatic test_deferred();
    logic [19:0] prev;
    start_run();
    repeat (5) tick();
    ftw_load = 1'b1; ftw_in = 32'h20000000;
    tick(); ftw_load = 1'b0;
    checks++;
    if (up_r !== 1'b1) begin
      errors++; $display("FAIL deferred_pending: got %b want 1", up_r);
    end
    for (int n = 0; n < 9; n++) begin
      prev = tgt_r;
      tick();
      checks++;
      if (20'(tgt_r - prev) !== 20'h40000) begin
        errors++; $display("FAIL deferred_old_step n=%0d: got %h want 40000", n, 20'(tgt_r - prev));
      end
    end
    line_start = 1'b1; tick(); line_start = 1'b0;
    checks++;
    if (tgt_r !== 20'h00000 || up_r !== 1'b0) begin
      errors++; $display("FAIL deferred_apply: got tgt=%h up=%b want 00000/0", tgt_r, up_r);
    end
    tick();
    checks++;
    if (tgt_r !== 20'h20000) begin
      errors++; $display("FAIL deferred_new_step: got %h want 20000", tgt_r);
    end
  endtask

  task automatic test_simultaneous();
    start_run();
    repeat (3) tick();
    offset_load = 1'b1; offset_in = 20'h12345; line_start = 1'b1;
    tick();
    offset_load = 1'b0; line_start = 1'b0;
    checks++;
    if (tgt_r !== 20'h12345 || up_r !== 1'b0) begin
      errors++; $display("FAIL simul_apply: got tgt=%h up=%b want 12345/0", tgt_r, up_r);
    end
    tick();
    checks++;
    if (tgt_r !== 20'h52345) begin
      errors++; $display("FAIL simul_next: got %h want 52345", tgt_r);
    end
  endtask

  task automatic test_line_phase();
    logic [19:0] want;
    idle_inputs();
    rst = 1'b1; enable = 1'b0; tick();
    rst = 1'b0; enable = 1'b1; tick(); tick();
    ftw_load = 1'b1; ftw_in = 32'h00100000; line_start = 1'b1;
    tick();
    ftw_load = 1'b0; line_start = 1'b0;
    checks++;
    if (lp_f !== 20'h00000) begin
      errors++; $display("FAIL line_phase_init: got %h want 00000", lp_f);
    end
    for (int j = 1; j <= 2; j++) begin
      repeat (99) tick();
      line_start = 1'b1; tick(); line_start = 1'b0;
      want = 20'(j * 32'h6400);
      checks++;
      if (lp_f !== want) begin
        errors++; $display("FAIL line_phase_free j=%0d: got %h want %h", j, lp_f, want);
      end
      checks++;
      if (lp_r !== 20'h06400) begin
        errors++; $display("FAIL line_phase_resync j=%0d: got %h want 06400", j, lp_r);
      end
    end
  endtask

  task automatic test_disable_reset();
    start_run();
    repeat (15) tick();
    enable = 1'b0; tick();
    checks++;
    if (av_r !== 1'b0 || tgt_r !== 20'h0 || sv_r !== 1'b1) begin
      errors++; $display("FAIL disable_now: got av=%b tgt=%h sv=%b want 0/00000/1", av_r, tgt_r, sv_r);
    end
    repeat (LAT - 1) tick();
    checks++;
    if (sv_r !== 1'b1) begin
      errors++; $display("FAIL disable_drain: got sv=%b want 1", sv_r);
    end
    tick();
    checks++;
    if (sv_r !== 1'b0) begin
      errors++; $display("FAIL disable_drop: got sv=%b want 0", sv_r);
    end
    start_run();
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({tgt_r, lp_r, av_r, sv_r, up_r} !== 43'd0) begin
      errors++; $display("FAIL reset_mid_run: got tgt=%h lp=%h av=%b sv=%b up=%b want all 0", tgt_r, lp_r, av_r, sv_r, up_r);
    end
    enable = 1'b0; line_start = 1'b1; tick(); line_start = 1'b0; tick();
    checks++;
    if ({tgt_r, lp_r, av_r, sv_r, up_r} !== 43'd0) begin
      errors++; $display("FAIL idle_line_start: got tgt=%h lp=%h av=%b sv=%b up=%b want all 0", tgt_r, lp_r, av_r, sv_r, up_r);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1'b1; enable = 1'b0; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 499) == 0);
      enable      = ($urandom_range(0, 63) != 0);
      line_start  = ($urandom_range(0, 39) == 0);
      ftw_load    = ($urandom_range(0, 15) == 0);
      offset_load = ($urandom_range(0, 15) == 0);
      ftw_in      = $urandom;
      offset_in   = 20'($urandom);
      tick();
      checks++;
      if ({tgt_r, lp_r, av_r, sv_r, up_r} !== {e_tgt_r, e_lp_r, e_av, e_sv, e_up}) begin
        errors++; $display("FAIL random_r c=%0d: got tgt=%h lp=%h av=%b sv=%b up=%b want %h/%h/%b/%b/%b",
                           c, tgt_r, lp_r, av_r, sv_r, up_r, e_tgt_r, e_lp_r, e_av, e_sv, e_up);
      end
      checks++;
      if ({tgt_f, lp_f, av_f, sv_f, up_f} !== {e_tgt_f, e_lp_f, e_av, e_sv, e_up}) begin
        errors++; $display("FAIL random_f c=%0d: got tgt=%h lp=%h av=%b sv=%b up=%b want %h/%h/%b/%b/%b",
                           c, tgt_f, lp_f, av_f, sv_f, up_f, e_tgt_f, e_lp_f, e_av, e_sv, e_up);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    idle_inputs();
    test_reset();
    test_startup();
    test_wrap();
    test_deferred();
    test_simultaneous();
    test_line_phase();
    test_disable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
